instruction_fetch_sequencer: RTL and testbench

Program-sequencing front end for the 28-bit instruction ROM. It owns the program counter, drives the ROM address, and registers each fetched word for the decode/execute stage. It honours decode back-pressure and branch/jump redirects from execute, and implements timed `NOP` delays: a `NOP` whose 24-bit immediate is nonzero suspends fetch for that many cycles. It sits between the combinational ROM and the decode stage of the teaching CPU.

---
 rtl/instruction_fetch_sequencer_if.sv | 50 +++++
 rtl/instruction_fetch_sequencer.sv | 112 +++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_sequencer_if.sv
// rtl/instruction_fetch_sequencer_if.sv - fetch sequencer ROM/decode/execute bundle
// Groups every non-clock signal of the fetch sequencer.
//   oRomAddress     : ROM address (PC register)
//   iRomInstruction : combinational ROM data for oRomAddress
//   oInstruction    : registered instruction to decode
//   oPC             : address oInstruction was fetched from
//   oValid          : oInstruction is live and on the correct path
//   iStall          : decode cannot accept, hold the current output
//   iRedirect       : taken branch/jump pulse
//   iRedirectAddr   : redirect target
//   oBusy           : timed-NOP delay in progress
// master = sequencer side, slave = ROM/decode/execute side.
interface instruction_fetch_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 28
);
    logic [ADDR_W-1:0] oRomAddress;
    logic [INSN_W-1:0] iRomInstruction;
    logic [INSN_W-1:0] oInstruction;
    logic [ADDR_W-1:0] oPC;
    logic              oValid;
    logic              iStall;
    logic              iRedirect;
    logic [ADDR_W-1:0] iRedirectAddr;
    logic              oBusy;

    modport master (
        output oRomAddress,
        input  iRomInstruction,
        output oInstruction,
        output oPC,
        output oValid,
        input  iStall,
        input  iRedirect,
        input  iRedirectAddr,
        output oBusy
    );

    modport slave (
        input  oRomAddress,
        output iRomInstruction,
        input  oInstruction,
        input  oPC,
        input  oValid,
        output iStall,
        output iRedirect,
        output iRedirectAddr,
        input  oBusy
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// rtl/instruction_fetch_sequencer.sv - program counter, ROM fetch and timed-NOP sequencer
// Owns the PC, presents it to a combinational ROM and registers each fetched
// word for decode. Honours decode stall, execute redirects, and suspends
// fetch for N cycles after a NOP whose operand N is nonzero.
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : instruction_fetch_sequencer_if.master (ROM, decode and redirect signals)
module instruction_fetch_sequencer #(
    parameter int       ADDR_W   = 16,
    parameter int       INSN_W   = 28,
    parameter logic [3:0] OP_NOP = 4'd0,
    parameter bit       DELAY_EN = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    instruction_fetch_sequencer_if.master bus
);

    localparam int OPND_W = INSN_W - 4;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DELAY = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSN_W-1:0]   insn_q;
    logic [ADDR_W-1:0]   opc_q;
    logic                valid_q;
    logic                busy_q;
    logic [OPND_W-1:0]   cnt_q;

    logic [3:0]          rom_opcode;
    logic [OPND_W-1:0]   rom_operand;
    logic                nop_delay;

    assign rom_opcode  = bus.iRomInstruction[INSN_W-1 -: 4];
    assign rom_operand = bus.iRomInstruction[OPND_W-1:0];

    // A NOP with a zero operand is an ordinary single instruction.
    assign nop_delay = DELAY_EN && (rom_opcode == OP_NOP) && (rom_operand != '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_FETCH;
            pc_q    <= '0;
            insn_q  <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bus.iRedirect) begin
                        // Redirect beats both stall and NOP capture.
                        pc_q    <= bus.iRedirectAddr;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (bus.iStall && valid_q) begin
                        // Hold the presented instruction; a bubble is never held.
                        pc_q    <= pc_q;
                    end else begin
                        insn_q  <= bus.iRomInstruction;
                        opc_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + ADDR_W'(1);
                        if (nop_delay) begin
                            cnt_q  <= rom_operand;
                            busy_q <= 1'b1;
                            state  <= ST_DELAY;
                        end
                    end
                end

                ST_DELAY: begin
                    if (bus.iRedirect) begin
                        state   <= ST_FETCH;
                        pc_q    <= bus.iRedirectAddr;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        // The counter runs even while decode stalls the NOP.
                        cnt_q <= cnt_q - OPND_W'(1);
                        if (!(bus.iStall && valid_q)) begin
                            valid_q <= 1'b0;
                        end
                        // The leaving edge itself does not fetch.
                        if (cnt_q == OPND_W'(1)) begin
                            state  <= ST_FETCH;
                            busy_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.oRomAddress  = pc_q;
    assign bus.oInstruction = insn_q;
    assign bus.oPC          = opc_q;
    assign bus.oValid       = valid_q;
    assign bus.oBusy        = busy_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb/tb_instruction_fetch_sequencer.sv - self-checking bench for instruction_fetch_sequencer
module tb_instruction_fetch_sequencer;

    localparam int         AW  = 16;
    localparam int         IW  = 28;
    localparam logic [3:0] NOP = 4'hF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] raddr = 16'h0;

    logic [27:0] rom [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    instruction_fetch_sequencer_if #(.ADDR_W(AW), .INSN_W(IW)) bus0 ();
    instruction_fetch_sequencer_if #(.ADDR_W(AW), .INSN_W(IW)) bus1 ();

    assign bus0.iStall          = stall;
    assign bus0.iRedirect       = redirect;
    assign bus0.iRedirectAddr   = raddr;
    assign bus0.iRomInstruction = rom[bus0.oRomAddress];
    assign bus1.iStall          = stall;
    assign bus1.iRedirect       = redirect;
    assign bus1.iRedirectAddr   = raddr;
    assign bus1.iRomInstruction = rom[bus1.oRomAddress];

    instruction_fetch_sequencer #(.ADDR_W(AW), .INSN_W(IW), .OP_NOP(NOP), .DELAY_EN(1'b1)) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus0)
    );

    instruction_fetch_sequencer #(.ADDR_W(AW), .INSN_W(IW), .OP_NOP(NOP), .DELAY_EN(1'b0)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus1)
    );

    // Reference: next fetch address, presented word, and the number of
    // remaining fetch-free edges owed to a timed NOP.
    typedef struct {
        logic [15:0] pc;
        logic [27:0] insn;
        logic [15:0] opc;
        logic        valid;
        int          gap;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t model_next(mstate_t s, bit en, bit rst, bit stl, bit rd, logic [15:0] tgt);
        mstate_t     n;
        logic [27:0] w;
        n = s;
        if (rst) begin
            n.pc = 16'h0; n.insn = 28'h0; n.opc = 16'h0; n.valid = 1'b0; n.gap = 0;
        end else if (rd) begin
            n.pc = tgt; n.valid = 1'b0; n.gap = 0;
        end else if (s.gap > 0) begin
            n.gap = s.gap - 1;
            if (!(stl && s.valid)) n.valid = 1'b0;
        end else if (stl && s.valid) begin
            n.valid = 1'b1;
        end else begin
            w       = rom[s.pc];
            n.insn  = w;
            n.opc   = s.pc;
            n.valid = 1'b1;
            n.pc    = s.pc + 16'd1;
            if (en && w[27:24] == NOP && w[23:0] != 24'd0) n.gap = int'(w[23:0]);
        end
        return n;
    endfunction

    function automatic logic [27:0] rom_default(int a);
        return {4'h1, 8'h00, 16'(a)};
    endfunction

    task automatic step(input bit rst, input bit stl, input bit rd, input logic [15:0] tgt);
        Reset    = rst;
        stall    = stl;
        redirect = rd;
        raddr    = tgt;
        @(posedge Clock);
        m0 = model_next(m0, 1'b1, rst, stl, rd, tgt);
        m1 = model_next(m1, 1'b0, rst, stl, rd, tgt);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            checks++;
            if ({bus0.oValid, bus0.oBusy, bus0.oPC, bus0.oInstruction, bus0.oRomAddress} !== 62'h0) begin
                errors++;
                $display("FAIL reset_state dut0: valid=%b busy=%b pc=%h insn=%h addr=%h, required all zero",
                         bus0.oValid, bus0.oBusy, bus0.oPC, bus0.oInstruction, bus0.oRomAddress);
            end
            checks++;
            if ({bus1.oValid, bus1.oBusy, bus1.oPC, bus1.oInstruction, bus1.oRomAddress} !== 62'h0) begin
                errors++;
                $display("FAIL reset_state dut1: valid=%b busy=%b pc=%h addr=%h, required all zero",
                         bus1.oValid, bus1.oBusy, bus1.oPC, bus1.oRomAddress);
            end
        end
    endtask

    task automatic test_run();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            checks++;
            if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'(i) || bus0.oInstruction !== rom_default(i)
                || bus0.oRomAddress !== 16'(i + 1)) begin
                errors++;
                $display("FAIL run step %0d: valid=%b pc=%h insn=%h addr=%h, required valid=1 pc=%h insn=%h addr=%h",
                         i, bus0.oValid, bus0.oPC, bus0.oInstruction, bus0.oRomAddress,
                         16'(i), rom_default(i), 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_pc [5];
        exp_pc = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd7};
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (bus0.oPC !== 16'd5 || bus0.oValid !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup: pc=%h valid=%b, required pc=0005 valid=1", bus0.oPC, bus0.oValid);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i < 3), 1'b0, 16'h0);
            checks++;
            if (bus0.oValid !== 1'b1 || bus0.oPC !== exp_pc[i] || bus0.oInstruction !== rom_default(int'(exp_pc[i]))) begin
                errors++;
                $display("FAIL stall step %0d: valid=%b pc=%h insn=%h, required valid=1 pc=%h",
                         i, bus0.oValid, bus0.oPC, bus0.oInstruction, exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0007);
        checks++;
        if (bus0.oValid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble: valid=%b, required 0", bus0.oValid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            checks++;
            if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'(7 + i)) begin
                errors++;
                $display("FAIL redirect_target %0d: valid=%b pc=%h, required valid=1 pc=%h",
                         i, bus0.oValid, bus0.oPC, 16'(7 + i));
            end
        end
    endtask

    task automatic test_nop();
        int busy_cycles;
        rom[9] = {NOP, 24'd4};
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'd9 || bus0.oBusy !== 1'b1) begin
            errors++;
            $display("FAIL nop_present: valid=%b pc=%h busy=%b, required valid=1 pc=0009 busy=1",
                     bus0.oValid, bus0.oPC, bus0.oBusy);
        end
        checks++;
        if (bus1.oValid !== 1'b1 || bus1.oPC !== 16'd9 || bus1.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL nop_present_nodelay: valid=%b pc=%h busy=%b, required valid=1 pc=0009 busy=0",
                     bus1.oValid, bus1.oPC, bus1.oBusy);
        end
        busy_cycles = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            if (bus0.oBusy === 1'b1) busy_cycles++;
            checks++;
            if (bus0.oValid !== 1'b0 || bus0.oBusy !== (i < 3)) begin
                errors++;
                $display("FAIL nop_delay cycle %0d: valid=%b busy=%b, required valid=0 busy=%b",
                         i, bus0.oValid, bus0.oBusy, (i < 3));
            end
            if (i == 0) begin
                checks++;
                if (bus1.oValid !== 1'b1 || bus1.oPC !== 16'd10) begin
                    errors++;
                    $display("FAIL nop_disabled_next: valid=%b pc=%h, required valid=1 pc=000a",
                             bus1.oValid, bus1.oPC);
                end
            end
        end
        checks++;
        if (busy_cycles !== 4) begin
            errors++;
            $display("FAIL nop_busy_len: busy for %0d cycles, required 4", busy_cycles);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'd10) begin
            errors++;
            $display("FAIL nop_resume: valid=%b pc=%h, required valid=1 pc=000a", bus0.oValid, bus0.oPC);
        end
        rom[9] = rom_default(9);
    endtask

    task automatic test_abort();
        int quiet;
        rom[0] = {NOP, 24'd4000};
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0002);
        checks++;
        if (bus0.oBusy !== 1'b0 || bus0.oValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_redirect: busy=%b valid=%b, required busy=0 valid=0", bus0.oBusy, bus0.oValid);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'd2 || bus0.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL abort_target: valid=%b pc=%h busy=%b, required valid=1 pc=0002 busy=0",
                     bus0.oValid, bus0.oPC, bus0.oBusy);
        end
        // Same again, aborted by Reset instead of a redirect.
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if ({bus0.oValid, bus0.oBusy, bus0.oPC, bus0.oInstruction, bus0.oRomAddress} !== 62'h0) begin
            errors++;
            $display("FAIL abort_reset_state: valid=%b busy=%b pc=%h addr=%h, required all zero",
                     bus0.oValid, bus0.oBusy, bus0.oPC, bus0.oRomAddress);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (bus0.oValid !== 1'b1 || bus0.oPC !== 16'd0 || bus0.oBusy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: valid=%b pc=%h busy=%b, required valid=1 pc=0000 busy=1",
                     bus0.oValid, bus0.oPC, bus0.oBusy);
        end
        quiet = 0;
        for (int i = 0; i < 4100; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            if (bus0.oValid === 1'b1) break;
            quiet++;
        end
        checks++;
        if (quiet !== 4000 || bus0.oPC !== 16'd1) begin
            errors++;
            $display("FAIL abort_full_delay: %0d quiet cycles then pc=%h, required 4000 then pc=0001",
                     quiet, bus0.oPC);
        end
        rom[0] = rom_default(0);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc = '{16'hFFFF, 16'h0000, 16'h0001};
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            checks++;
            if (bus0.oValid !== 1'b1 || bus0.oPC !== exp_pc[i] || bus0.oInstruction !== rom_default(int'(exp_pc[i]))) begin
                errors++;
                $display("FAIL wrap %0d: valid=%b pc=%h insn=%h, required valid=1 pc=%h",
                         i, bus0.oValid, bus0.oPC, bus0.oInstruction, exp_pc[i]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        bit rst, stl, rd;
        for (int a = 16'h0100; a < 16'h0180; a++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      rom[a] = {NOP, 24'($urandom_range(1, 6))};
            else if (r == 1) rom[a] = {NOP, 24'd0};
            else             rom[a] = {4'($urandom_range(1, 14)), 24'($urandom)};
        end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0100);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            stl = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 6);
            step(rst, stl, rd, 16'h0100 + 16'($urandom_range(0, 63)));
            checks++;
            if (bus0.oValid !== m0.valid || bus0.oBusy !== (m0.gap > 0) || bus0.oRomAddress !== m0.pc) begin
                errors++;
                $display("FAIL random dut0 cycle %0d: valid=%b busy=%b addr=%h, required valid=%b busy=%b addr=%h",
                         i, bus0.oValid, bus0.oBusy, bus0.oRomAddress, m0.valid, (m0.gap > 0), m0.pc);
            end
            if (m0.valid) begin
                checks++;
                if (bus0.oPC !== m0.opc || bus0.oInstruction !== m0.insn) begin
                    errors++;
                    $display("FAIL random dut0 data cycle %0d: pc=%h insn=%h, required pc=%h insn=%h",
                             i, bus0.oPC, bus0.oInstruction, m0.opc, m0.insn);
                end
            end
            checks++;
            if (bus1.oValid !== m1.valid || bus1.oBusy !== 1'b0 || bus1.oRomAddress !== m1.pc
                || (m1.valid && (bus1.oPC !== m1.opc || bus1.oInstruction !== m1.insn))) begin
                errors++;
                $display("FAIL random dut1 cycle %0d: valid=%b busy=%b addr=%h pc=%h, required valid=%b busy=0 addr=%h pc=%h",
                         i, bus1.oValid, bus1.oBusy, bus1.oRomAddress, bus1.oPC, m1.valid, m1.pc, m1.opc);
            end
        end
        for (int a = 16'h0100; a < 16'h0180; a++) rom[a] = rom_default(a);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = rom_default(a);
        m0 = '{pc: 16'h0, insn: 28'h0, opc: 16'h0, valid: 1'b0, gap: 0};
        m1 = m0;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_nop();
        test_abort();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
